// File: rtl/qos_stream_pkg.sv
// qos_stream_pkg: default stream widths and beat layout shared by the QoS packet FIFO and arbiter
package qos_stream_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_QOS_WIDTH  = 4;
    localparam int DEF_DATA_DEPTH = 16;
    localparam int DEF_PKT_DEPTH  = 4;
    typedef struct packed {
        logic                      last;
        logic [DEF_DATA_WIDTH-1:0] data;
    } beat_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; pointers carry an extra MSB to tell full from empty
module sync_fifo import qos_stream_pkg::*; #(
    parameter int WIDTH = DEF_DATA_WIDTH + 1,
    parameter int DEPTH = DEF_DATA_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic push_ok, pop_ok;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign full_o  = wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]};
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/stream_qos_packet_fifo.sv
// stream_qos_packet_fifo: store-and-forward packet buffer with per-packet QoS, feeding one arbiter input
module stream_qos_packet_fifo import qos_stream_pkg::*; #(
    parameter int T_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int T_QOS__WIDTH = DEF_QOS_WIDTH,
    parameter int DATA_DEPTH   = DEF_DATA_DEPTH,
    parameter int PKT_DEPTH    = DEF_PKT_DEPTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [T_DATA_WIDTH-1:0]        s_data_i,
    input  logic [T_QOS__WIDTH-1:0]        s_qos_i,
    input  logic                           s_last_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    output logic [T_DATA_WIDTH-1:0]        m_data_o,
    output logic [T_QOS__WIDTH-1:0]        m_qos_o,
    output logic                           m_last_o,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [$clog2(PKT_DEPTH+1)-1:0] pkt_cnt_o
);
    localparam int CW = $clog2(PKT_DEPTH+1);
    logic [T_DATA_WIDTH:0] beat_head;
    logic [T_QOS__WIDTH-1:0] qos_head;
    logic beat_full, beat_empty, qos_full, qos_empty;
    logic s_acc, m_acc, m_done;
    logic in_pkt_q, in_pkt_d, jumbo_q, jumbo_d, ready_en_q;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    assign s_acc     = s_valid_i & s_ready_o;
    assign m_acc     = m_valid_o & m_ready_i;
    assign m_done    = m_acc & m_last_o;
    assign pkt_cnt_o = pkt_cnt_q;
    sync_fifo #(.WIDTH(T_DATA_WIDTH + 1), .DEPTH(DATA_DEPTH)) u_beat_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(s_acc), .data_i({s_last_i, s_data_i}),
        .pop_i(m_acc), .data_o(beat_head), .full_o(beat_full), .empty_o(beat_empty)
    );
    sync_fifo #(.WIDTH(T_QOS__WIDTH), .DEPTH(PKT_DEPTH)) u_qos_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(s_acc & ~in_pkt_q), .data_i(s_qos_i),
        .pop_i(m_done), .data_o(qos_head), .full_o(qos_full), .empty_o(qos_empty)
    );
    // A full beat store with no complete packet means the head packet can never fit: cut through.
    always_comb begin
        s_ready_o = ready_en_q & ~beat_full & (in_pkt_q | ~qos_full);
        m_valid_o = ~beat_empty & ((pkt_cnt_q != '0) | jumbo_q);
        m_data_o  = beat_empty ? '0 : beat_head[T_DATA_WIDTH-1:0];
        m_last_o  = ~beat_empty & beat_head[T_DATA_WIDTH];
        m_qos_o   = qos_empty ? '0 : qos_head;
        in_pkt_d  = s_acc ? ~s_last_i : in_pkt_q;
        pkt_cnt_d = pkt_cnt_q + CW'(s_acc & s_last_i) - CW'(m_done);
        jumbo_d   = (jumbo_q & ~m_done) | (beat_full & (pkt_cnt_q == '0));
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_pkt_q   <= 1'b0;
            jumbo_q    <= 1'b0;
            pkt_cnt_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            in_pkt_q   <= in_pkt_d;
            jumbo_q    <= jumbo_d;
            pkt_cnt_q  <= pkt_cnt_d;
            ready_en_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stream_qos_packet_fifo.sv
// tb_stream_qos_packet_fifo: directed packets checked against a queue-based packet model every cycle
module tb_stream_qos_packet_fifo;
    logic clk = 1'b0, rst_i = 1'b1;
    logic [7:0] s_data_i = '0;
    logic [3:0] s_qos_i = '0;
    logic s_last_i = 1'b0, s_valid_i = 1'b0, m_ready_i = 1'b0;
    logic s_ready_o, m_last_o, m_valid_o;
    logic [7:0] m_data_o;
    logic [3:0] m_qos_o;
    logic [2:0] pkt_cnt_o;
    int n_checks = 0, n_fail = 0;

    stream_qos_packet_fifo dut (
        .clk_i(clk), .rst_i(rst_i), .s_data_i(s_data_i), .s_qos_i(s_qos_i),
        .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_last_o(m_last_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .pkt_cnt_o(pkt_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: stored beats {last,data} and per-packet QoS as queues; complete packets = stored last beats.
    logic [8:0] bq[$];
    logic [3:0] qq[$];
    bit m_in_pkt = 0, m_jumbo = 0, m_started = 0, acc, pop, jn;

    function automatic int nlast();
        int n = 0;
        foreach (bq[i]) if (bq[i][8]) n++;
        return n;
    endfunction
    function automatic bit e_ready();
        return m_started && bq.size() < 16 && (m_in_pkt || qq.size() < 4);
    endfunction
    function automatic bit e_valid();
        return bq.size() > 0 && (nlast() > 0 || m_jumbo);
    endfunction

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            bq.delete(); qq.delete();
            m_in_pkt = 0; m_jumbo = 0; m_started = 0;
        end else begin
            acc = s_valid_i && e_ready();
            pop = e_valid() && m_ready_i;
            jn = (m_jumbo && !(pop && bq[0][8])) || (bq.size() == 16 && nlast() == 0);
            if (pop) begin
                if (bq[0][8]) void'(qq.pop_front());
                void'(bq.pop_front());
            end
            if (acc) begin
                if (!m_in_pkt) qq.push_back(s_qos_i);
                bq.push_back({s_last_i, s_data_i});
                m_in_pkt = !s_last_i;
            end
            m_jumbo = jn;
            m_started = 1;
        end
    end

    always @(negedge clk) begin
        chk("s_ready", 32'(s_ready_o), 32'(e_ready()));
        chk("m_valid", 32'(m_valid_o), 32'(e_valid()));
        chk("pkt_cnt", 32'(pkt_cnt_o), 32'(nlast()));
        chk("m_data", 32'(m_data_o), bq.size() > 0 ? 32'(bq[0][7:0]) : 32'h0);
        chk("m_last", 32'(m_last_o), bq.size() > 0 ? 32'(bq[0][8]) : 32'h0);
        chk("m_qos", 32'(m_qos_o), bq.size() > 0 ? 32'(qq[0]) : 32'h0);
    end

    logic [7:0] cap_d[$];
    logic [3:0] cap_q[$];
    logic cap_l[$];
    always @(posedge clk) begin
        if (!rst_i && m_valid_o && m_ready_i) begin
            cap_d.push_back(m_data_o);
            cap_q.push_back(m_qos_o);
            cap_l.push_back(m_last_o);
        end
    end

    task automatic clear_cap();
        cap_d.delete(); cap_q.delete(); cap_l.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] q, input logic l);
        int n = 0;
        logic r;
        s_data_i = d; s_qos_i = q; s_last_i = l; s_valid_i = 1'b1;
        forever begin
            #1 r = s_ready_o;
            @(negedge clk);
            if (r) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
        s_valid_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready_o), 32'd0);
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
        chk("rst_m_data", 32'(m_data_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(s_ready_o), 32'd1);

        // single 3-beat packet, qos 5
        m_ready_i = 1'b1;
        clear_cap();
        send(8'hA1, 4'd5, 1'b0);
        chk("t1_no_valid_partial", 32'(m_valid_o), 32'd0);
        send(8'hA2, 4'd5, 1'b0);
        send(8'hA3, 4'd5, 1'b1);
        chk("t1_valid_after_last", 32'(m_valid_o), 32'd1);
        chk("t1_head_data", 32'(m_data_o), 32'hA1);
        chk("t1_head_qos", 32'(m_qos_o), 32'd5);
        repeat (4) @(negedge clk);
        chk("t1_beats", 32'(cap_d.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap_d.size(); i++) begin
            chk("t1_data", 32'(cap_d[i]), 32'hA1 + 32'(i));
            chk("t1_qos", 32'(cap_q[i]), 32'd5);
            chk("t1_last", 32'(cap_l[i]), 32'(i == 2));
        end

        // four 1-beat packets fill the QoS store
        m_ready_i = 1'b0;
        clear_cap();
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 4'(i + 1), 1'b1);
        chk("t2_ready_low", 32'(s_ready_o), 32'd0);
        chk("t2_pkt_cnt", 32'(pkt_cnt_o), 32'd4);
        s_data_i = 8'h14; s_qos_i = 4'd15; s_last_i = 1'b1; s_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        s_valid_i = 1'b0;
        chk("t2_fifth_refused", 32'(pkt_cnt_o), 32'd4);
        m_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        chk("t2_beats", 32'(cap_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_q.size(); i++) chk("t2_qos_order", 32'(cap_q[i]), 32'(i + 1));

        // QoS changes mid-packet are ignored
        m_ready_i = 1'b0;
        clear_cap();
        send(8'hB0, 4'd2, 1'b0);
        send(8'hB1, 4'd9, 1'b0);
        send(8'hB2, 4'd9, 1'b1);
        m_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("t3_beats", 32'(cap_q.size()), 32'd3);
        foreach (cap_q[i]) chk("t3_qos_held", 32'(cap_q[i]), 32'd2);

        // 20-beat jumbo packet cuts through
        clear_cap();
        for (int i = 0; i < 20; i++) send(8'h40 + 8'(i), 4'd7, 1'(i == 19));
        repeat (25) @(negedge clk);
        chk("t4_beats", 32'(cap_d.size()), 32'd20);
        for (int i = 0; i < 20 && i < cap_d.size(); i++) begin
            chk("t4_data", 32'(cap_d[i]), 32'h40 + 32'(i));
            chk("t4_last", 32'(cap_l[i]), 32'(i == 19));
        end
        chk("t4_pkt_cnt_end", 32'(pkt_cnt_o), 32'd0);

        // simultaneous input last and output last with one complete packet resident
        m_ready_i = 1'b0;
        send(8'h50, 4'd1, 1'b1);
        chk("t5_pkt_cnt_before", 32'(pkt_cnt_o), 32'd1);
        send(8'h60, 4'd6, 1'b0);
        s_data_i = 8'h61; s_last_i = 1'b1; s_valid_i = 1'b1; m_ready_i = 1'b1;
        #1;
        chk("t5_both_ready", 32'({s_ready_o, m_valid_o, m_last_o}), 32'b111);
        @(negedge clk);
        s_valid_i = 1'b0; m_ready_i = 1'b0;
        chk("t5_pkt_cnt_same", 32'(pkt_cnt_o), 32'd1);
        chk("t5_head_data", 32'(m_data_o), 32'h60);
        chk("t5_head_qos", 32'(m_qos_o), 32'd6);
        m_ready_i = 1'b1;
        repeat (4) @(negedge clk);

        // asynchronous reset mid-packet
        m_ready_i = 1'b0;
        send(8'h70, 4'd8, 1'b1);
        send(8'h71, 4'd8, 1'b0);
        s_data_i = 8'h72; s_last_i = 1'b0; s_valid_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        chk("t6_valid_drop", 32'(m_valid_o), 32'd0);
        chk("t6_pkt_cnt_clr", 32'(pkt_cnt_o), 32'd0);
        chk("t6_ready_low", 32'(s_ready_o), 32'd0);
        @(negedge clk);
        s_valid_i = 1'b0;
        rst_i = 1'b0;
        @(negedge clk);
        clear_cap();
        m_ready_i = 1'b1;
        send(8'hC0, 4'd3, 1'b0);
        send(8'hC1, 4'd3, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_beats", 32'(cap_d.size()), 32'd2);
        for (int i = 0; i < 2 && i < cap_d.size(); i++) begin
            chk("t6_data", 32'(cap_d[i]), 32'hC0 + 32'(i));
            chk("t6_qos", 32'(cap_q[i]), 32'd3);
            chk("t6_last", 32'(cap_l[i]), 32'(i == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
